// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE pad controller slice.
package pe_ctrl_pkg;

    localparam int PAD_SIZE  = 12;
    localparam int CONF_D_WD = 4;
    localparam int O_CNT_WD  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        FILL   = 3'd2,
        RUN    = 3'd3,
        REFILL = 3'd4,
        DONE   = 3'd5
    } PadCtrlState;

    typedef struct packed {
        logic [CONF_D_WD-1:0] kLen;
        logic [O_CNT_WD-1:0]  oLen;
        logic                 noSpReuse;
    } PadCfg;

endpackage

// File: rtl/pe_pad_ctrl_wrap_cnt.sv
// Wrapping counter: counts enabled events, flags when the count equals the
// terminal value and wraps back to zero on the enabled event at terminal.
module wrap_cnt #(
    parameter int Width = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    assign tc_o = (cnt_q == term_i);

    // Next count: clear wins, otherwise step or wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_pad_ctrl.sv
// Per-PE sequencer for the pixel pad and its weight pad: clears the pad,
// fills a window, streams output pixels and reports job completion.
// Optional performance counters are built when PE_PAD_CTRL_PERF_EN is defined.
module pe_pad_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int PadSize = PAD_SIZE,
    parameter int ConfDWd = CONF_D_WD,
    parameter int OCntWd  = O_CNT_WD
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [ConfDWd-1:0] i_cfg_kLen,
    input  logic [OCntWd-1:0]  i_cfg_oLen,
    input  logic               i_cfg_noSpReuse,
    input  logic               i_stall,
    input  logic               i_rd_fire,
    input  logic               i_wr_fire,
    output logic               o_cont_reset,
    output logic               o_cont_start,
    output logic               o_cont_stall,
    output logic               o_cont_pop,
    output logic               o_cont_lastPix,
    output logic               o_cont_done,
    output logic               o_cont_swapWt,
    output logic [ConfDWd-1:0] o_cont_IFLen,
    output logic               o_cont_noSpReuse,
    output logic               o_busy
`ifdef PE_PAD_CTRL_PERF_EN
    ,
    output logic [15:0]        o_perf_stallCnt,
    output logic [15:0]        o_perf_fillCnt
`endif
);

    PadCtrlState state_q, state_d;
    PadCfg       cfg_q, cfg_d;
    logic        start_q, start_d;

    logic inData;
    logic inFill;
    logic stallEff;
    logic wrEn, rdEn, oEn;
    logic wTc, rTc, oTc;
    logic clrCnt;

    assign inFill   = (state_q == FILL) || (state_q == REFILL);
    assign inData   = inFill || (state_q == RUN);
    assign stallEff = i_stall && inData;
    assign clrCnt   = (state_q == CLR);

    assign wrEn = inFill && i_wr_fire && !i_stall;
    assign rdEn = (state_q == RUN) && i_rd_fire && !i_stall;
    assign oEn  = rdEn && rTc;

    wrap_cnt #(.Width(ConfDWd)) uWcnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .clr_i  (clrCnt),
        .en_i   (wrEn),
        .term_i (cfg_q.kLen),
        .tc_o   (wTc)
    );

    wrap_cnt #(.Width(ConfDWd)) uRcnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .clr_i  (clrCnt),
        .en_i   (rdEn),
        .term_i (cfg_q.kLen),
        .tc_o   (rTc)
    );

    wrap_cnt #(.Width(OCntWd)) uOcnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .clr_i  (clrCnt),
        .en_i   (oEn),
        .term_i (cfg_q.oLen),
        .tc_o   (oTc)
    );

    // Next state and config latch; stalls freeze every data-phase transition.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        start_d = (state_q == CLR);
        unique case (state_q)
            IDLE: begin
                if (i_cfg_valid) begin
                    cfg_d.kLen      = (int'(i_cfg_kLen) > PadSize - 1) ?
                                      ConfDWd'(PadSize - 1) : i_cfg_kLen;
                    cfg_d.oLen      = i_cfg_oLen;
                    cfg_d.noSpReuse = i_cfg_noSpReuse;
                    state_d         = CLR;
                end
            end
            CLR: begin
                state_d = FILL;
            end
            FILL, REFILL: begin
                if (wrEn && wTc) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (oEn) begin
                    if (oTc) begin
                        state_d = DONE;
                    end else if (cfg_q.noSpReuse) begin
                        state_d = REFILL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched config and the start/swap pulse register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            start_q <= start_d;
        end
    end

    assign o_cfg_ready      = (state_q == IDLE);
    assign o_busy           = (state_q != IDLE);
    assign o_cont_reset     = (state_q == CLR);
    assign o_cont_start     = start_q;
    assign o_cont_swapWt    = start_q;
    assign o_cont_stall     = stallEff;
    assign o_cont_pop       = inFill || ((state_q == RUN) && !cfg_q.noSpReuse);
    assign o_cont_lastPix   = (state_q == RUN) && rTc;
    assign o_cont_done      = (state_q == DONE);
    assign o_cont_IFLen     = cfg_q.kLen;
    assign o_cont_noSpReuse = cfg_q.noSpReuse;

`ifdef PE_PAD_CTRL_PERF_EN
    logic [15:0] stallCnt_q, stallCnt_d;
    logic [15:0] fillCnt_q, fillCnt_d;

    // Saturating stall and fill cycle counters, cleared at job start.
    always_comb begin
        stallCnt_d = stallCnt_q;
        fillCnt_d  = fillCnt_q;
        if (clrCnt) begin
            stallCnt_d = '0;
            fillCnt_d  = '0;
        end else begin
            if (stallEff && (stallCnt_q != 16'hFFFF)) begin
                stallCnt_d = stallCnt_q + 16'd1;
            end
            if (inFill && (fillCnt_q != 16'hFFFF)) begin
                fillCnt_d = fillCnt_q + 16'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stallCnt_q <= '0;
            fillCnt_q  <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            fillCnt_q  <= fillCnt_d;
        end
    end

    assign o_perf_stallCnt = stallCnt_q;
    assign o_perf_fillCnt  = fillCnt_q;
`endif

endmodule

// File: tb/tb_pe_pad_ctrl.sv
// Scoreboard bench for pe_pad_ctrl: the stimulus plays whole jobs from the
// window rules and queues the expected pad events; a monitor checks them.
`timescale 1ns/1ps
module tb_pe_pad_ctrl;

    localparam int ConfDWd = 4;
    localparam int OCntWd  = 8;

    logic               i_clk = 1'b0;
    logic               i_rstn = 1'b0;
    logic               i_cfg_valid = 1'b0;
    logic               o_cfg_ready;
    logic [ConfDWd-1:0] i_cfg_kLen = '0;
    logic [OCntWd-1:0]  i_cfg_oLen = '0;
    logic               i_cfg_noSpReuse = 1'b0;
    logic               i_stall = 1'b0;
    logic               i_rd_fire = 1'b0;
    logic               i_wr_fire = 1'b0;
    logic               o_cont_reset, o_cont_start, o_cont_stall, o_cont_pop;
    logic               o_cont_lastPix, o_cont_done, o_cont_swapWt;
    logic [ConfDWd-1:0] o_cont_IFLen;
    logic               o_cont_noSpReuse, o_busy;
`ifdef PE_PAD_CTRL_PERF_EN
    logic [15:0]        o_perf_stallCnt, o_perf_fillCnt;
`endif

    always #5 i_clk = ~i_clk;

    pe_pad_ctrl #(.PadSize(12), .ConfDWd(ConfDWd), .OCntWd(OCntWd)) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_cfg_valid      (i_cfg_valid),
        .o_cfg_ready      (o_cfg_ready),
        .i_cfg_kLen       (i_cfg_kLen),
        .i_cfg_oLen       (i_cfg_oLen),
        .i_cfg_noSpReuse  (i_cfg_noSpReuse),
        .i_stall          (i_stall),
        .i_rd_fire        (i_rd_fire),
        .i_wr_fire        (i_wr_fire),
        .o_cont_reset     (o_cont_reset),
        .o_cont_start     (o_cont_start),
        .o_cont_stall     (o_cont_stall),
        .o_cont_pop       (o_cont_pop),
        .o_cont_lastPix   (o_cont_lastPix),
        .o_cont_done      (o_cont_done),
        .o_cont_swapWt    (o_cont_swapWt),
        .o_cont_IFLen     (o_cont_IFLen),
        .o_cont_noSpReuse (o_cont_noSpReuse),
        .o_busy           (o_busy)
`ifdef PE_PAD_CTRL_PERF_EN
        ,
        .o_perf_stallCnt  (o_perf_stallCnt),
        .o_perf_fillCnt   (o_perf_fillCnt)
`endif
    );

    typedef enum int {EV_RESET, EV_START, EV_WRITE, EV_READ, EV_DONE} EvKind;
    typedef struct {
        EvKind kind;
        int    cyc;
        int    lastPix;
        int    kLen;
        int    noSp;
    } Ev;

    Ev  evQ[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit dataPhase = 1'b0;
    bit monEn = 1'b0;

    // Free-running cycle number shared by stimulus and monitor.
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic popEvent(input EvKind kind, output Ev e, output bit ok);
        checks++;
        ok = 1'b0;
        if (evQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL event: got %s at cycle %0d, expected no event",
                     kind.name(), cyc);
        end else begin
            e = evQ.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                         kind.name(), cyc, e.kind.name(), e.cyc);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: compare every pad-visible event against the scoreboard queue.
    always @(negedge i_clk) begin
        Ev  e;
        bit ok;
        if (i_rstn && monEn) begin
            checkOutput("stall", o_cont_stall, i_stall && dataPhase);
            if (o_cont_reset) begin
                popEvent(EV_RESET, e, ok);
            end
            if (o_cont_start || o_cont_swapWt) begin
                popEvent(EV_START, e, ok);
                if (ok) begin
                    checkOutput("start", o_cont_start, 1);
                    checkOutput("swapWt", o_cont_swapWt, 1);
                    checkOutput("startIFLen", o_cont_IFLen, e.kLen);
                    checkOutput("startNoSp", o_cont_noSpReuse, e.noSp);
                end
            end
            if (i_wr_fire && !i_stall) begin
                popEvent(EV_WRITE, e, ok);
                if (ok) checkOutput("popOnWrite", o_cont_pop, 1);
            end
            if (i_rd_fire && !i_stall) begin
                popEvent(EV_READ, e, ok);
                if (ok) begin
                    checkOutput("lastPix", o_cont_lastPix, e.lastPix);
                    checkOutput("popOnRead", o_cont_pop, (e.noSp == 0));
                    checkOutput("readIFLen", o_cont_IFLen, e.kLen);
                end
            end
            if (o_cont_done) begin
                popEvent(EV_DONE, e, ok);
            end
        end
    end

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
        i_cfg_valid = 1'b0;
        i_rd_fire   = 1'b0;
        i_wr_fire   = 1'b0;
        i_stall     = 1'b0;
    endtask

    task automatic busyCfgPulse();
        if ($urandom_range(0, 9) == 0) begin
            i_cfg_valid     = 1'b1;
            i_cfg_kLen      = 4'($urandom_range(0, 15));
            i_cfg_oLen      = 8'($urandom_range(0, 255));
            i_cfg_noSpReuse = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rstCfgReady", o_cfg_ready, 1);
        checkOutput("rstReset", o_cont_reset, 0);
        checkOutput("rstStart", o_cont_start, 0);
        checkOutput("rstStall", o_cont_stall, 0);
        checkOutput("rstPop", o_cont_pop, 0);
        checkOutput("rstLastPix", o_cont_lastPix, 0);
        checkOutput("rstDone", o_cont_done, 0);
        checkOutput("rstSwapWt", o_cont_swapWt, 0);
        checkOutput("rstIFLen", o_cont_IFLen, 0);
        checkOutput("rstNoSp", o_cont_noSpReuse, 0);
        checkOutput("rstBusy", o_busy, 0);
`ifdef PE_PAD_CTRL_PERF_EN
        checkOutput("rstStallCnt", o_perf_stallCnt, 0);
        checkOutput("rstFillCnt", o_perf_fillCnt, 0);
`endif
    endtask

    // One job: k+1 writes per window (first window only when reusing),
    // k+1 reads per window, o+1 windows, done the cycle after the last read.
    task automatic applyStimulus(input int k, input int o, input int noSp,
                                 input int stallPct, input int idlePct,
                                 input int stallAfterRead, input int stallLen,
                                 input int abortAtWrite, output int jobCycles);
        int h, reads, writes, forceStall, lastRd, stallCyc, fillCyc;
        bit aborted;
        reads = 0; writes = 0; forceStall = 0; lastRd = 0;
        stallCyc = 0; fillCyc = 0; aborted = 1'b0; jobCycles = 0;

        nextCycle();
        checkOutput("cfgReadyIdle", o_cfg_ready, 1);
        i_cfg_valid     = 1'b1;
        i_cfg_kLen      = 4'(k);
        i_cfg_oLen      = 8'(o);
        i_cfg_noSpReuse = 1'(noSp);
        i_stall         = 1'($urandom_range(0, 1));
        h = cyc;
        evQ.push_back('{EV_RESET, h + 1, 0, k, noSp});
        evQ.push_back('{EV_START, h + 2, 0, k, noSp});

        nextCycle();
        checkOutput("cfgReadyBusy", o_cfg_ready, 0);
        i_stall = 1'($urandom_range(0, 1));
        busyCfgPulse();

        for (int w = 0; w <= o && !aborted; w++) begin
            if (w == 0 || noSp != 0) begin
                for (int j = 0; j <= k; ) begin
                    nextCycle();
                    dataPhase = 1'b1;
                    fillCyc++;
                    busyCfgPulse();
                    if (forceStall > 0 || $urandom_range(0, 99) < stallPct) begin
                        i_stall = 1'b1;
                        stallCyc++;
                        if (forceStall > 0) forceStall--;
                    end else if ($urandom_range(0, 99) >= idlePct) begin
                        i_wr_fire = 1'b1;
                        evQ.push_back('{EV_WRITE, cyc, 0, k, noSp});
                        j++;
                        writes++;
                        if (writes == abortAtWrite) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (!aborted) begin
                for (int j = 0; j <= k; ) begin
                    nextCycle();
                    dataPhase = 1'b1;
                    busyCfgPulse();
                    if (forceStall > 0 || $urandom_range(0, 99) < stallPct) begin
                        i_stall = 1'b1;
                        stallCyc++;
                        if (forceStall > 0) forceStall--;
                    end else if ($urandom_range(0, 99) >= idlePct) begin
                        i_rd_fire = 1'b1;
                        evQ.push_back('{EV_READ, cyc, (j == k), k, noSp});
                        j++;
                        reads++;
                        lastRd = cyc;
                        if (reads == stallAfterRead) forceStall = stallLen;
                    end
                end
            end
        end

        if (aborted) begin
            nextCycle();
            i_rstn    = 1'b0;
            dataPhase = 1'b0;
            #1;
            checkResetValues();
            evQ.delete();
            repeat (2) nextCycle();
            i_rstn = 1'b1;
        end else begin
            evQ.push_back('{EV_DONE, lastRd + 1, 0, k, noSp});
            nextCycle();
            dataPhase = 1'b0;
            i_stall   = 1'($urandom_range(0, 1));
            busyCfgPulse();
            nextCycle();
            checkOutput("cfgReadyAfter", o_cfg_ready, 1);
            checkOutput("busyAfter", o_busy, 0);
            jobCycles = cyc - h + 1;
`ifdef PE_PAD_CTRL_PERF_EN
            checkOutput("perfStallCnt", o_perf_stallCnt, stallCyc);
            checkOutput("perfFillCnt", o_perf_fillCnt, fillCyc);
`endif
        end
    endtask

    initial begin
        int len;
        #1;
        checkResetValues();
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        monEn  = 1'b1;

        applyStimulus(2, 3, 0, 0, 0, -1, 0, -1, len);
        checkOutput("reuseJobCycles", len, 19);
        applyStimulus(2, 3, 1, 0, 0, -1, 0, -1, len);
        checkOutput("noReuseJobCycles", len, 28);
        applyStimulus(0, 0, 0, 0, 0, -1, 0, -1, len);
        checkOutput("k0JobCycles", len, 6);
        applyStimulus(2, 3, 0, 0, 0, 4, 5, -1, len);
        checkOutput("stallJobCycles", len, 24);
        applyStimulus(3, 5, 1, 0, 0, -1, 0, 6, len);
        applyStimulus(1, 1, 0, 0, 0, -1, 0, -1, len);
        checkOutput("afterAbortJobCycles", len, 10);
        applyStimulus(11, 2, 0, 10, 20, -1, 0, -1, len);
        applyStimulus(0, 255, 0, 5, 10, -1, 0, -1, len);
        for (int n = 0; n < 25; n++) begin
            applyStimulus($urandom_range(0, 11), $urandom_range(0, 7),
                          $urandom_range(0, 1), 15, 25, -1, 0, -1, len);
        end

        repeat (3) nextCycle();
        checkOutput("queueEmpty", evQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_pad_ctrl.md
Name: pe_pad_ctrl

Overview:
- Per-PE sequencer for the input-feature pad (12x16b RF-based pixel pad) and its companion weight pad.
- Accepts a window configuration and drives the pad control bundle: reset, start, stall, pop, lastPix, done, swapWt, IFLen, noSpReuse.
- Tracks pixel-in-window and output-pixel counts from the pad's read/write handshake fires, and signals job completion to the PE array controller.

Parameters:
- PadSize, 12, pad depth in words.
- ConfDWd, 4, width of window-length config; must satisfy 2**ConfDWd >= PadSize.
- OCntWd, 8, width of output-pixel count config.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_cfg_valid  in  1  job config valid.
- o_cfg_ready  out  1  high only in IDLE.
- i_cfg_kLen  in  ConfDWd  window length minus 1; legal range 0..PadSize-1.
- i_cfg_oLen  in  OCntWd  output pixels per job minus 1.
- i_cfg_noSpReuse  in  1  1 = refill whole window per output; 0 = slide by one pixel.
- i_stall  in  1  global backpressure from the array.
- i_rd_fire  in  1  pad opix valid&&ready.
- i_wr_fire  in  1  pad ipix valid&&ready.
- o_cont_reset  out  1  pad synchronous reset.
- o_cont_start  out  1  one-cycle start pulse.
- o_cont_stall  out  1  pad stall.
- o_cont_pop  out  1  pad may accept new pixels.
- o_cont_lastPix  out  1  current read is the last of its window.
- o_cont_done  out  1  job-end pulse.
- o_cont_swapWt  out  1  weight pad swap pulse.
- o_cont_IFLen  out  ConfDWd  latched kLen.
- o_cont_noSpReuse  out  1  latched noSpReuse.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0 except o_cfg_ready=1; state IDLE; all counters 0.
- FSM states: IDLE, CLR, FILL, RUN, REFILL, DONE.
- IDLE:
  - On i_cfg_valid && o_cfg_ready: latch kLen, oLen, noSpReuse; go to CLR.
- CLR (1 cycle):
  - o_cont_reset=1 to pad.
  - Next cycle: o_cont_start=1 and o_cont_swapWt=1 for exactly one cycle; state FILL.
- FILL:
  - o_cont_pop=1.
  - wcnt increments per i_wr_fire.
  - When wcnt==kLen && i_wr_fire: wcnt<=0, state RUN.
- RUN:
  - o_cont_pop = !noSpReuse (one pixel ahead per window).
  - rcnt increments per i_rd_fire; o_cont_lastPix = (rcnt==kLen), combinational.
  - On i_rd_fire with lastPix: rcnt<=0, ocnt++.
  - If ocnt==oLen: state DONE.
  - Else if noSpReuse: state REFILL.
- REFILL:
  - Identical to FILL (kLen+1 writes), then back to RUN.
- DONE:
  - o_cont_done=1 for one cycle; then IDLE.
- Stall:
  - o_cont_stall = i_stall && state in {FILL,RUN,REFILL}.
  - While stalled, counters and state freeze; fires arriving during stall are ignored (pad guarantees none).
- Wrap/width:
  - rcnt and wcnt are ConfDWd wide and compare equal to kLen, never to PadSize.
  - ocnt is OCntWd wide; oLen=2**OCntWd-1 is legal and must not overflow before the compare.
- kLen=0: every read is lastPix; FILL takes one write.
- Simultaneous fires: i_rd_fire and i_wr_fire in the same cycle are both counted; a write in RUN with reuse does not change state.
- Config handshake: i_cfg_valid outside IDLE is ignored, since o_cfg_ready=0.
- Reset mid-job: async reset returns the block to IDLE with all outputs at reset values; the next job always passes through CLR.

Optional Feature:
- Macro PE_PAD_CTRL_PERF_EN.
- Defined:
  - Adds output o_perf_stallCnt (16b): counts cycles with o_cont_stall=1, saturates at 0xFFFF, cleared in CLR.
  - Adds output o_perf_fillCnt (16b): counts cycles spent in FILL/REFILL, saturates at 0xFFFF, cleared in CLR.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - PadCtrlState enum (logic [2:0]).
  - PadCfg struct {kLen, oLen, noSpReuse}.
  - Constant PAD_SIZE=12.
- One sub-module, wrap_cnt: a parameterized counter with enable, clear, terminal-value input, and terminal flag. Instantiated for rcnt, wcnt and ocnt.

Test Plan:
- Job kLen=2, oLen=3, reuse, no stall, pad always ready:
  - Reset pulse at cycle 1, start and swapWt at cycle 2.
  - 3 writes in FILL; 12 reads total, with lastPix on reads 3/6/9/12.
  - done exactly 1 cycle after the 12th read; o_cfg_ready returns.
- Same job with noSpReuse=1:
  - 3 writes before each window (12 writes total), and o_cont_pop=0 during RUN.
- kLen=0, oLen=0:
  - 1 write, 1 read with lastPix=1, done; 6 cycles total from cfg handshake.
- i_stall held 5 cycles mid-RUN after the 4th read:
  - o_cont_stall high 5 cycles; rcnt/ocnt unchanged; sequence resumes identically.
  - Perf build: stallCnt=5.
- Assert i_rstn low during REFILL:
  - All outputs at reset values immediately.
  - A new cfg is accepted in the first cycle after release and passes through CLR.
- i_cfg_valid pulsed while busy:
  - Ignored; latched kLen unchanged on o_cont_IFLen.
